qspi_arbiter: RTL and testbench
===============================

Name: qspi_arbiter

Overview:
- Shares the single QSPI memory controller between four requesters: debug (index 0), lisa1 (1), lisa2 (2) and ttlc (3).
- Each requester presents the same valid/ready/xfer_len request interface that the debug register block drives.
- The arbiter picks one winner, applies that requester's base-address offset and chip-select control, and holds the grant for the whole burst.
- It sits between the requester cores/debug_regs and the QSPI controller.

Parameters:
- CHIP_SELECTS, 2, number of QSPI chip-select lines (width of each ce_ctrl field).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  4  per-requester request valid; bit n = requester n
- req_addr  in  96  per-requester 24-bit byte address, requester n at [24n+23:24n]
- req_wdata  in  64  per-requester 16-bit write data, [16n+15:16n]
- req_wstrb  in  8  per-requester byte strobes, [2n+1:2n]; 0 means read
- req_xfer_len  in  16  per-requester word count minus 1, [4n+3:4n]
- req_ce_ctrl  in  4*CHIP_SELECTS  per-requester chip-select enables
- base_addr  in  48  base for requesters 1..3, [16(n-1)+15:16(n-1)]; debug has no base
- req_ready  out  4  per-word ready back to requesters
- req_rdata  out  16  read data, broadcast to all requesters
- grant  out  4  one-hot current owner; 0 when idle
- m_valid  out  1  request to QSPI controller
- m_addr  out  24  translated start address
- m_wdata  out  16  write data of owner
- m_wstrb  out  2  strobes of owner
- m_xfer_len  out  4  latched word count minus 1
- m_ce_ctrl  out  CHIP_SELECTS  latched chip-select enables of owner
- m_ready  in  1  controller word-complete pulse
- m_rdata  in  16  controller read data

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-burst):
  - state = IDLE; grant = 0; m_valid = 0; m_addr = 0; m_xfer_len = 0; m_ce_ctrl = 0; word count = 0.
  - Round-robin pointer = 3, so lisa1 is searched first after reset.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - If any req_valid is set, pick a winner on the clock edge; at least one cycle of arbitration latency.
  - Priority: debug (bit 0) wins whenever valid.
  - Otherwise round-robin among 1..3, starting at the index after the pointer. The pointer updates to the winner (debug wins do not move it).
  - On the winning edge, register:
    - grant one-hot;
    - m_addr = req_addr[n] + {base_addr[n], 8'h00}, modulo 2^24 (wraps, no carry out); debug uses req_addr[0] unchanged;
    - m_xfer_len = req_xfer_len[n];
    - m_ce_ctrl = req_ce_ctrl[n];
    - count = 0.
  - Then go to BUSY.
- BUSY:
  - m_valid = 1.
  - m_wdata and m_wstrb are combinational muxes of the owner's inputs.
  - req_ready[owner] = m_ready; every other req_ready bit = 0.
  - req_rdata = m_rdata at all times.
  - On m_ready: if count == m_xfer_len, go to RELEASE; else count increments by 1.
  - Abort: if req_valid[owner] = 0 in BUSY, go to RELEASE next edge. No req_ready is issued in that cycle even if m_ready is high, and the controller must discard the word.
- RELEASE:
  - m_valid = 0 and grant = 0 for exactly one cycle, so CE deasserts between owners.
  - Then IDLE. Back-to-back requests see at least a 2-cycle gap from the last m_ready to the next m_valid.
- Non-owner valid requests wait; no preemption, including by debug.
- Inputs other than valid are ignored in IDLE except on the winning edge.
- Address, length and ce_ctrl changes mid-burst are ignored because those fields are latched.
- grant is never more than one-hot (assertion target).
- m_valid is 1 only in BUSY.

Test Plan:
- Reset, then lisa1 valid with addr 0x000010, base_addr[1] 0x0120, xfer_len 0 -> grant = 4'b0010 one cycle later; m_addr = 0x012010; one m_ready gives req_ready[1] one pulse; RELEASE with m_valid = 0 for 1 cycle; then IDLE.
- lisa1, lisa2 and ttlc all valid continuously, xfer_len 0 -> grant order 1, 2, 3, 1, 2, 3; no owner repeats while another is pending.
- Debug and ttlc valid together in IDLE -> debug granted. If debug is asserted while ttlc is mid-burst with xfer_len 3 -> ttlc receives all 4 m_ready pulses before debug is granted.
- ttlc burst with xfer_len 3 on a write with m_wstrb 2'b11 and changing wdata -> m_wdata tracks req_wdata[3] each word; exactly 4 req_ready[3] pulses; count wraps back to 0 for the next grant.
- Address wrap: lisa2 addr 0xFFFF00, base 0x0001 -> m_addr = 0x000000.
- Abort and reset:
  - Owner drops req_valid after 1 of 4 words -> RELEASE next edge, m_valid = 0.
  - rst asserted mid-burst -> m_valid and grant = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/qspi_arbiter.sv
// Four-way arbiter in front of the single QSPI controller: debug has fixed priority,
// lisa1/lisa2/ttlc share round-robin, and the grant is held for a whole burst.
module qspi_arbiter #(
  parameter int CHIP_SELECTS = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [3:0]                i_req_valid,
  input  logic [95:0]               i_req_addr,
  input  logic [63:0]               i_req_wdata,
  input  logic [7:0]                i_req_wstrb,
  input  logic [15:0]               i_req_xfer_len,
  input  logic [4*CHIP_SELECTS-1:0] i_req_ce_ctrl,
  input  logic [47:0]               i_base_addr,
  output logic [3:0]                o_req_ready,
  output logic [15:0]               o_req_rdata,
  output logic [3:0]                o_grant,
  output logic                      o_m_valid,
  output logic [23:0]               o_m_addr,
  output logic [15:0]               o_m_wdata,
  output logic [1:0]                o_m_wstrb,
  output logic [3:0]                o_m_xfer_len,
  output logic [CHIP_SELECTS-1:0]   o_m_ce_ctrl,
  input  logic                      i_m_ready,
  input  logic [15:0]               i_m_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [1:0]              r_owner;
  logic [1:0]              r_rr_ptr;
  logic [3:0]              r_grant;
  logic [3:0]              r_count;
  logic [3:0]              r_xfer_len;
  logic [23:0]             r_addr;
  logic [CHIP_SELECTS-1:0] r_ce_ctrl;

  logic [23:0]             w_addr    [4];
  logic [15:0]             w_base    [4];
  logic [15:0]             w_wdata   [4];
  logic [1:0]              w_wstrb   [4];
  logic [3:0]              w_len     [4];
  logic [CHIP_SELECTS-1:0] w_ce      [4];
  logic [1:0]              w_winner;
  logic                    w_win;
  logic                    w_owner_valid;
  logic                    w_word_done;
  logic                    w_last_word;
  logic [23:0]             w_addr_xlat;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_addr[n]  = i_req_addr[n*24 +: 24];
      w_wdata[n] = i_req_wdata[n*16 +: 16];
      w_wstrb[n] = i_req_wstrb[n*2 +: 2];
      w_len[n]   = i_req_xfer_len[n*4 +: 4];
      w_ce[n]    = i_req_ce_ctrl[n*CHIP_SELECTS +: CHIP_SELECTS];
    end
    // debug addresses the flash directly, so its base is forced to zero
    w_base[0] = 16'h0000;
    for (int n = 1; n < 4; n++) begin
      w_base[n] = i_base_addr[(n-1)*16 +: 16];
    end
  end

  // Search starts at the requester after the last round-robin winner.
  always_comb begin
    w_winner = 2'd0;
    if (!i_req_valid[0]) begin
      case (r_rr_ptr)
        2'd1:    w_winner = i_req_valid[2] ? 2'd2 : (i_req_valid[3] ? 2'd3 : 2'd1);
        2'd2:    w_winner = i_req_valid[3] ? 2'd3 : (i_req_valid[1] ? 2'd1 : 2'd2);
        default: w_winner = i_req_valid[1] ? 2'd1 : (i_req_valid[2] ? 2'd2 : 2'd3);
      endcase
    end
  end

  assign w_win         = (r_state == S_IDLE) && (|i_req_valid);
  assign w_owner_valid = i_req_valid[r_owner];
  assign w_word_done   = (r_state == S_BUSY) && w_owner_valid && i_m_ready;
  assign w_last_word   = w_word_done && (r_count == r_xfer_len);
  assign w_addr_xlat   = w_addr[w_winner] + {w_base[w_winner], 8'h00};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_win) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (!w_owner_valid || w_last_word) w_state_nxt = S_RELEASE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_m_valid   = 1'b0;
    o_grant     = 4'b0000;
    o_req_ready = 4'b0000;
    o_m_wdata   = 16'h0000;
    o_m_wstrb   = 2'b00;
    if (r_state == S_BUSY) begin
      o_m_valid = 1'b1;
      o_grant   = r_grant;
      o_m_wdata = w_wdata[r_owner];
      o_m_wstrb = w_wstrb[r_owner];
      // an aborting owner gets no ready; the controller drops that word
      if (w_owner_valid && i_m_ready) o_req_ready = r_grant;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_owner    <= 2'd0;
      r_grant    <= 4'b0000;
      r_rr_ptr   <= 2'd3;
      r_addr     <= 24'h000000;
      r_xfer_len <= 4'h0;
      r_ce_ctrl  <= '0;
      r_count    <= 4'h0;
    end else if (w_win) begin
      r_owner    <= w_winner;
      r_grant    <= 4'b0001 << w_winner;
      r_addr     <= w_addr_xlat;
      r_xfer_len <= w_len[w_winner];
      r_ce_ctrl  <= w_ce[w_winner];
      r_count    <= 4'h0;
      if (w_winner != 2'd0) r_rr_ptr <= w_winner;
    end else if (w_word_done && !w_last_word) begin
      r_count <= r_count + 4'h1;
    end
  end

  assign o_m_addr     = r_addr;
  assign o_m_xfer_len = r_xfer_len;
  assign o_m_ce_ctrl  = r_ce_ctrl;
  assign o_req_rdata  = i_m_rdata;

endmodule

// File: tb/tb_qspi_arbiter.sv
// Scoreboard bench for qspi_arbiter: a round-level model predicts the grant sequence,
// a monitor pops expectations on each new grant and checks every busy cycle.
module tb_qspi_arbiter;
  localparam int CS = 2;

  typedef struct {
    int             id;
    logic [23:0]    addr;
    logic [3:0]     len;
    logic [CS-1:0]  ce;
    int             words;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [3:0]      valid;
  logic [23:0]     a_addr  [4];
  logic [15:0]     a_wdata [4];
  logic [1:0]      a_wstrb [4];
  logic [3:0]      a_len   [4];
  logic [CS-1:0]   a_ce    [4];
  logic [15:0]     a_base  [4];
  logic            m_ready;
  logic [15:0]     m_rdata;

  logic [95:0]     req_addr;
  logic [63:0]     req_wdata;
  logic [7:0]      req_wstrb;
  logic [15:0]     req_len;
  logic [4*CS-1:0] req_ce;
  logic [47:0]     base_addr;

  logic [3:0]      o_req_ready;
  logic [15:0]     o_req_rdata;
  logic [3:0]      o_grant;
  logic            o_m_valid;
  logic [23:0]     o_m_addr;
  logic [15:0]     o_m_wdata;
  logic [1:0]      o_m_wstrb;
  logic [3:0]      o_m_xfer_len;
  logic [CS-1:0]   o_m_ce_ctrl;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_ptr    = 3;

  assign req_addr  = {a_addr[3], a_addr[2], a_addr[1], a_addr[0]};
  assign req_wdata = {a_wdata[3], a_wdata[2], a_wdata[1], a_wdata[0]};
  assign req_wstrb = {a_wstrb[3], a_wstrb[2], a_wstrb[1], a_wstrb[0]};
  assign req_len   = {a_len[3], a_len[2], a_len[1], a_len[0]};
  assign req_ce    = {a_ce[3], a_ce[2], a_ce[1], a_ce[0]};
  assign base_addr = {a_base[3], a_base[2], a_base[1]};

  qspi_arbiter #(.CHIP_SELECTS(CS)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(valid), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .i_req_wstrb(req_wstrb), .i_req_xfer_len(req_len), .i_req_ce_ctrl(req_ce),
    .i_base_addr(base_addr),
    .o_req_ready(o_req_ready), .o_req_rdata(o_req_rdata), .o_grant(o_grant),
    .o_m_valid(o_m_valid), .o_m_addr(o_m_addr), .o_m_wdata(o_m_wdata),
    .o_m_wstrb(o_m_wstrb), .o_m_xfer_len(o_m_xfer_len), .o_m_ce_ctrl(o_m_ce_ctrl),
    .i_m_ready(m_ready), .i_m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int id, input int abort_id);
    exp_t        e;
    logic [31:0] s;
    s = {8'h00, a_addr[id]};
    if (id != 0) s = s + ({16'h0000, a_base[id]} * 32'd256);
    e.id    = id;
    e.addr  = s[23:0];
    e.len   = a_len[id];
    e.ce    = a_ce[id];
    e.words = (id == abort_id) ? 1 : int'(a_len[id]) + 1;
    return e;
  endfunction

  task automatic rand_fields(input int i);
    a_addr[i]  = 24'($urandom);
    a_wdata[i] = 16'($urandom);
    a_wstrb[i] = 2'($urandom);
    a_len[i]   = 4'($urandom_range(0, 3));
    a_ce[i]    = CS'($urandom);
    a_base[i]  = 16'($urandom);
  endtask

  // One round: every requester in 'set' raises valid together and holds it
  // until its burst is served (or aborted after one word).
  task automatic run_round(input logic [3:0] set, input bit late_dbg, input int abort_id);
    exp_t       order[$];
    int         last;
    int         cnt  [4];
    int         lenx [4];
    bit         late_done;
    bit         abort_now;
    logic [3:0] rdy;
    int         cyc;
    last = m_ptr;
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = ((m_ptr - 1 + k) % 3) + 1;
      if (set[idx]) begin
        order.push_back(mk(idx, abort_id));
        last = idx;
      end
    end
    m_ptr = last;
    if (set[0]) order.push_front(mk(0, abort_id));
    if (late_dbg) order.insert(1, mk(0, abort_id));
    foreach (order[j]) q.push_back(order[j]);
    for (int i = 0; i < 4; i++) begin
      cnt[i]  = 0;
      lenx[i] = int'(a_len[i]);
    end
    late_done = 1'b0;
    @(posedge clk); #1;
    valid = valid | set;
    for (cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      rdy = o_req_ready;
      if (valid == 4'b0000 && q.size() == 0 && o_grant == 4'b0000) break;
      @(posedge clk); #1;
      abort_now = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (rdy[i]) begin
          cnt[i]++;
          if (i == abort_id && cnt[i] == 1) begin
            valid[i]  = 1'b0;
            abort_now = 1'b1;
          end else if (cnt[i] == lenx[i] + 1) begin
            valid[i] = 1'b0;
          end else begin
            a_wdata[i] = 16'($urandom);
            a_addr[i]  = 24'($urandom);
            a_len[i]   = 4'($urandom);
            a_ce[i]    = CS'($urandom);
          end
        end
      end
      if (late_dbg && !late_done && rdy != 4'b0000) begin
        valid[0]  = 1'b1;
        late_done = 1'b1;
      end
      m_ready = abort_now ? 1'b1 : ($urandom_range(0, 2) != 0);
      m_rdata = 16'($urandom);
    end
    if (cyc >= 1000) begin
      n_checks++;
      n_fail++;
      $display("FAIL round_timeout: got %0d pending expected 0", q.size());
      valid = 4'b0000;
      q.delete();
    end
  endtask

  // Monitor
  initial begin
    logic [3:0] prev_g;
    logic [3:0] exp_rdy;
    exp_t       cur;
    bit         have;
    int         words;
    int         gap;
    prev_g = 4'b0000;
    have   = 1'b0;
    words  = 0;
    gap    = 100;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_g = 4'b0000;
        have   = 1'b0;
        gap    = 100;
        continue;
      end
      if (o_grant != 4'b0000) begin
        if (prev_g == 4'b0000) begin
          check("release_gap", 32'(gap >= 2), 32'd1);
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_grant: got %b expected none", o_grant);
            have = 1'b0;
          end else begin
            cur   = q.pop_front();
            have  = 1'b1;
            words = 0;
          end
        end
        check("grant_onehot", 32'($onehot(o_grant)), 32'd1);
        check("m_valid_busy", 32'(o_m_valid), 32'd1);
        if (have) begin
          check("grant_owner", 32'(o_grant), 32'(4'b0001 << cur.id));
          check("m_addr", 32'(o_m_addr), 32'(cur.addr));
          check("m_xfer_len", 32'(o_m_xfer_len), 32'(cur.len));
          check("m_ce_ctrl", 32'(o_m_ce_ctrl), 32'(cur.ce));
          exp_rdy = (m_ready && valid[cur.id]) ? (4'b0001 << cur.id) : 4'b0000;
          check("req_ready", 32'(o_req_ready), 32'(exp_rdy));
          if (valid[cur.id]) begin
            check("m_wdata", 32'(o_m_wdata), 32'(a_wdata[cur.id]));
            check("m_wstrb", 32'(o_m_wstrb), 32'(a_wstrb[cur.id]));
          end
          if (o_req_ready[cur.id]) words++;
        end
        gap = 0;
      end else begin
        check("m_valid_idle", 32'(o_m_valid), 32'd0);
        check("ready_idle", 32'(o_req_ready), 32'd0);
        if (prev_g != 4'b0000 && have) begin
          check("burst_words", 32'(words), 32'(cur.words));
          have = 1'b0;
        end
        gap++;
      end
      check("req_rdata", 32'(o_req_rdata), 32'(m_rdata));
      prev_g = o_grant;
    end
  end

  initial begin
    logic [3:0] set;
    bit         late;
    int         ab;
    bit         got;
    rst     = 1'b1;
    valid   = 4'b0000;
    m_ready = 1'b0;
    m_rdata = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      a_addr[i] = '0; a_wdata[i] = '0; a_wstrb[i] = '0;
      a_len[i]  = '0; a_ce[i]    = '0; a_base[i]  = '0;
    end
    #11;
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_m_valid", 32'(o_m_valid), 32'd0);
    check("rst_m_addr", 32'(o_m_addr), 32'd0);
    check("rst_m_xfer_len", 32'(o_m_xfer_len), 32'd0);
    check("rst_m_ce_ctrl", 32'(o_m_ce_ctrl), 32'd0);
    #1 rst = 1'b0;

    // lisa1 single word with base translation
    a_addr[1] = 24'h000010; a_base[1] = 16'h0120; a_len[1] = 4'd0; a_ce[1] = 2'b01;
    run_round(4'b0010, 1'b0, -1);

    // three round-robin requesters, single words, twice
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i < 4; i++) begin rand_fields(i); a_len[i] = 4'd0; end
      run_round(4'b1110, 1'b0, -1);
    end

    // debug beats ttlc when both are valid
    rand_fields(0); rand_fields(3);
    run_round(4'b1001, 1'b0, -1);

    // debug arrives mid-burst and must wait for all four ttlc words
    rand_fields(0); rand_fields(3); a_len[3] = 4'd3;
    run_round(4'b1000, 1'b1, -1);

    // ttlc four-word write with changing data
    rand_fields(3); a_len[3] = 4'd3; a_wstrb[3] = 2'b11;
    run_round(4'b1000, 1'b0, -1);

    // address wrap
    rand_fields(2); a_addr[2] = 24'hFFFF00; a_base[2] = 16'h0001;
    run_round(4'b0100, 1'b0, -1);

    // owner drops valid after one word of four
    rand_fields(3); a_len[3] = 4'd3;
    run_round(4'b1000, 1'b0, 3);

    for (int r = 0; r < 60; r++) begin
      set = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) rand_fields(i);
      late = !set[0] && ($urandom_range(0, 3) == 0);
      ab   = -1;
      if ($urandom_range(0, 4) == 0) begin
        for (int i = 1; i < 4; i++) if (set[i] && ab < 0) ab = i;
        if (ab >= 0) a_len[ab] = 4'd3;
      end
      run_round(set, late, ab);
    end

    // asynchronous reset in the middle of a lisa2 burst
    m_ready = 1'b0;
    rand_fields(2); a_len[2] = 4'd3;
    q.push_back(mk(2, -1));
    @(posedge clk); #1;
    valid[2] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (o_grant == 4'b0100) got = 1'b1;
    end
    check("reset_test_grant", 32'(got), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_m_valid", 32'(o_m_valid), 32'd0);
    check("async_rst_grant", 32'(o_grant), 32'd0);
    check("async_rst_m_addr", 32'(o_m_addr), 32'd0);
    check("async_rst_m_xfer_len", 32'(o_m_xfer_len), 32'd0);
    valid = 4'b0000;
    q.delete();
    m_ptr = 3;
    @(negedge clk); #1;
    rst = 1'b0;

    // pointer restarts at lisa1 after reset
    for (int i = 1; i < 4; i++) rand_fields(i);
    run_round(4'b1110, 1'b0, -1);

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
